// File: rtl/ps2_pkg.sv
// Shared constants for the PS/2 receiver: FSM encodings, prefix bytes, frame sizes.
package ps2_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DATA   = 2'd1;
    localparam logic [1:0] ST_PARITY = 2'd2;
    localparam logic [1:0] ST_STOP   = 2'd3;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;

    localparam int DATA_BITS = 8;

endpackage

// File: rtl/ps2_filter.sv
// Synchronizes a raw PS/2 line and filters it: the output level only follows the
// input after FILTER_LEN consecutive agreeing samples. Emits a one-cycle pulse on
// every filtered falling edge.
module ps2_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic fall
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] agree_cnt;

    // Two-flop synchronizer; idles high like the bus
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
        end else begin
            sync_p0 <= raw;
            sync_p1 <= sync_p0;
        end
    end

    // Agreement counter: flip the filtered level after FILTER_LEN differing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            agree_cnt <= '0;
            level     <= 1'b1;
            fall      <= 1'b0;
        end else begin
            fall <= 1'b0;
            if (sync_p1 != level) begin
                if (agree_cnt == CW'(FILTER_LEN - 1)) begin
                    agree_cnt <= '0;
                    level     <= sync_p1;
                    fall      <= ~sync_p1;
                end else begin
                    agree_cnt <= agree_cnt + 1'b1;
                end
            end else begin
                agree_cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: deserializes 11-bit frames into scan codes, checks
// parity/stop, recovers from stalled frames and folds F0/E0 prefixes into flags.
module ps2_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic       parity_err,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_level;
    logic          clk_fall;
    logic          fall;
    logic          data_p0;
    logic          data_p1;
    logic [1:0]    state;
    logic [1:0]    cur_state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          parity_bit;
    logic          break_pnd;
    logic          ext_pnd;
    logic [TW-1:0] to_cnt;
    logic          timeout_hit;

    ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .clk   (clk),
        .reset (reset),
        .raw   (ps2_clk),
        .level (clk_level),
        .fall  (clk_fall)
    );

    // A fall pulse always coincides with the filtered level dropping low
    assign fall = clk_fall & ~clk_level;

    // Data only needs synchronizing; it is stable around the clock edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_p0 <= 1'b1;
            data_p1 <= 1'b1;
        end else begin
            data_p0 <= ps2_data;
            data_p1 <= data_p0;
        end
    end

    // An expired timeout turns the current cycle into an IDLE cycle, so a
    // coincident edge is judged as a possible start bit
    assign timeout_hit = (state != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYCLES));
    assign cur_state   = timeout_hit ? ST_IDLE : state;

    // Stall watchdog: counts idle time inside an open frame, saturating
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt <= '0;
        end else if (fall || state == ST_IDLE || timeout_hit) begin
            to_cnt <= '0;
        end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // Payload shift register and parity capture, LSB first
    always_ff @(posedge clk) begin
        if (fall && cur_state == ST_DATA) begin
            shreg <= {data_p1, shreg[7:1]};
        end
        if (fall && cur_state == ST_PARITY) begin
            parity_bit <= data_p1;
        end
    end

    // Frame FSM, prefix folding and registered output strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            bit_cnt    <= '0;
            break_pnd  <= 1'b0;
            ext_pnd    <= 1'b0;
            scan_code  <= '0;
            code_valid <= 1'b0;
            is_break   <= 1'b0;
            is_ext     <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            if (timeout_hit) begin
                frame_err <= 1'b1;
                break_pnd <= 1'b0;
                ext_pnd   <= 1'b0;
                state     <= ST_IDLE;
            end
            if (fall) begin
                case (cur_state)
                    ST_IDLE: begin
                        if (!data_p1) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'(DATA_BITS - 1)) begin
                            state <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        state <= ST_STOP;
                    end
                    default: begin
                        state <= ST_IDLE;
                        if (!data_p1) begin
                            frame_err <= 1'b1;
                            break_pnd <= 1'b0;
                            ext_pnd   <= 1'b0;
                        end else if (!(^{shreg, parity_bit})) begin
                            parity_err <= 1'b1;
                            break_pnd  <= 1'b0;
                            ext_pnd    <= 1'b0;
                        end else if (shreg == PS2_BREAK) begin
                            break_pnd <= 1'b1;
                        end else if (shreg == PS2_EXT) begin
                            ext_pnd <= 1'b1;
                        end else begin
                            scan_code  <= shreg;
                            code_valid <= 1'b1;
                            is_break   <= break_pnd;
                            is_ext     <= ext_pnd;
                            break_pnd  <= 1'b0;
                            ext_pnd    <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule
